// File: rtl/bp_pkg.sv
// Shared types for the branch predictor update path.
package bp_pkg;

  localparam int BQ_LOG_DEPTH = 3;

  typedef logic [31:0] pc_t;

  // One outstanding branch: its PC and the direction the predictor chose.
  typedef struct packed {
    pc_t  pc;
    logic predicted;
  } bq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush. The head entry is presented combinationally
// on rd_data, so a pop and a use of the popped data happen in the same cycle.
module sync_fifo
  import bp_pkg::*;
#(
  parameter type T         = bq_entry_t,
  parameter int  LOG_DEPTH = BQ_LOG_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               wr_en,
  input  T                   wr_data,
  input  logic               rd_en,
  output T                   rd_data,
  output logic               full,
  output logic               empty,
  output logic [LOG_DEPTH:0] count
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  T                     mem [DEPTH];
  logic [LOG_DEPTH-1:0] head;
  logic [LOG_DEPTH-1:0] tail;
  logic                 wr_ok;
  logic                 rd_ok;

  // count never exceeds DEPTH, so its MSB alone marks full.
  assign full    = count[LOG_DEPTH];
  assign empty   = (count == '0);
  // A flush drops any same-cycle write; a read still completes so the
  // caller can consume the head entry on its way out.
  assign wr_ok   = wr_en & ~full & ~flush;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[head];

  // Entry storage; never reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[tail] <= wr_data;
  end

  // Pointers wrap naturally at LOG_DEPTH bits; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) tail <= tail + 1'b1;
      if (rd_ok) head <= head + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_update_queue.sv
// Holds predicted branches in fetch order and, as each resolves in order,
// drives the predictor's update port one cycle later with the mispredict flag
// and running statistics.
module branch_update_queue
  import bp_pkg::*;
#(
  parameter int LOG_DEPTH = BQ_LOG_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [31:0]        push_pc,
  input  logic               push_taken,
  output logic               push_ready,
  input  logic               resolve,
  input  logic               resolve_taken,
  input  logic               flush,
  output logic               update,
  output logic [31:0]        update_pc,
  output logic               was_taken,
  output logic               mispredict,
  output logic [LOG_DEPTH:0] count,
  output logic [31:0]        resolved_total,
  output logic [31:0]        mispredict_total
);

  bq_entry_t wr_entry;
  bq_entry_t head_entry;
  logic      full;
  logic      empty;
  logic      resolve_ok;
  logic      miss_now;

  assign wr_entry = '{pc: push_pc, predicted: push_taken};

  sync_fifo #(
    .T         (bq_entry_t),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (resolve),
    .rd_data (head_entry),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Readiness looks only at current occupancy: a same-cycle resolve does not
  // free a slot for a push, and a resolve on an empty queue never bypasses.
  assign push_ready = ~full;
  assign resolve_ok = resolve & ~empty;
  assign miss_now   = resolve_ok & (resolve_taken != head_entry.predicted);

  // Registered update port and statistics; pc/direction hold between updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      update           <= 1'b0;
      mispredict       <= 1'b0;
      update_pc        <= '0;
      was_taken        <= 1'b0;
      resolved_total   <= '0;
      mispredict_total <= '0;
    end else begin
      update     <= resolve_ok;
      mispredict <= miss_now;
      if (resolve_ok) begin
        update_pc      <= head_entry.pc;
        was_taken      <= resolve_taken;
        resolved_total <= resolved_total + 32'd1;
      end
      if (miss_now) mispredict_total <= mispredict_total + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: a reference queue models occupancy,
// a scoreboard holds expected update-port results until the DUT produces them.
module tb_branch_update_queue;
  import bp_pkg::*;

  localparam int LD    = 3;
  localparam int DEPTH = 1 << LD;

  logic          clk = 1'b0;
  logic          reset, push, push_taken, resolve, resolve_taken, flush;
  logic [31:0]   push_pc;
  logic          push_ready, update, was_taken, mispredict;
  logic [31:0]   update_pc, resolved_total, mispredict_total;
  logic [LD:0]   count;

  typedef struct {
    logic [31:0] pc;
    logic        wt;
    logic        mis;
  } exp_t;

  bq_entry_t   mq[$];
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_res = 0, exp_mis = 0, last_pc = 0;
  logic        last_wt = 0;

  branch_update_queue #(.LOG_DEPTH(LD)) dut (
    .clk              (clk),
    .reset            (reset),
    .push             (push),
    .push_pc          (push_pc),
    .push_taken       (push_taken),
    .push_ready       (push_ready),
    .resolve          (resolve),
    .resolve_taken    (resolve_taken),
    .flush            (flush),
    .update           (update),
    .update_pc        (update_pc),
    .was_taken        (was_taken),
    .mispredict       (mispredict),
    .count            (count),
    .resolved_total   (resolved_total),
    .mispredict_total (mispredict_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic post_check(input bit exp_upd);
    exp_t e;
    chk("count", {{(31-LD){1'b0}}, count}, 32'(mq.size()));
    chk("update", {31'b0, update}, {31'b0, exp_upd});
    if (exp_upd) begin
      e       = sb.pop_front();
      last_pc = e.pc;
      last_wt = e.wt;
      chk("mispredict", {31'b0, mispredict}, {31'b0, e.mis});
    end else begin
      chk("mispredict_idle", {31'b0, mispredict}, 32'd0);
    end
    chk("update_pc", update_pc, last_pc);
    chk("was_taken", {31'b0, was_taken}, {31'b0, last_wt});
    chk("resolved_total", resolved_total, exp_res);
    chk("mispredict_total", mispredict_total, exp_mis);
  endtask

  task automatic step(input bit p, input logic [31:0] pc, input bit pt,
                      input bit r, input bit rt, input bit f);
    bit        r_ok, p_ok;
    bq_entry_t e;
    chk("push_ready", {31'b0, push_ready}, {31'b0, (mq.size() < DEPTH)});
    push = p; push_pc = pc; push_taken = pt;
    resolve = r; resolve_taken = rt; flush = f;
    r_ok = r && (mq.size() > 0);
    p_ok = p && (mq.size() < DEPTH) && !f;
    if (r_ok) begin
      e = mq.pop_front();
      sb.push_back('{e.pc, rt, (rt != e.predicted)});
      exp_res++;
      if (rt != e.predicted) exp_mis++;
    end
    if (f) mq.delete();
    if (p_ok) mq.push_back('{pc: pc, predicted: pt});
    @(posedge clk); #1;
    push = 0; resolve = 0; flush = 0;
    post_check(r_ok);
  endtask

  task automatic do_reset(input bit with_traffic);
    reset = 1; push = with_traffic; push_pc = 32'hDEAD; push_taken = 1;
    resolve = with_traffic; resolve_taken = 1; flush = 0;
    @(posedge clk); #1;
    reset = 0; push = 0; resolve = 0;
    mq.delete(); sb.delete();
    exp_res = 0; exp_mis = 0; last_pc = 0; last_wt = 0;
    post_check(0);
  endtask

  initial begin
    reset = 1; push = 0; push_pc = 0; push_taken = 0;
    resolve = 0; resolve_taken = 0; flush = 0;
    do_reset(0);
    do_reset(0);

    // single mispredicted branch
    step(1, 32'h100, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // fill to depth, overflow push dropped, drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 32'(i * 4), i[0], 0, 0, 0);
    step(1, 32'h20, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, i[1], 0);

    // resolve on empty queue alongside a push: no bypass
    step(1, 32'h40, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // flush with resolve and push in the same cycle
    for (int i = 0; i < 3; i++) step(1, 32'h200 + 32'(i * 4), 1, 0, 0, 0);
    step(1, 32'h99, 0, 1, 1, 1);
    step(0, 0, 0, 1, 0, 0);

    // pointer wrap: 12 push/resolve pairs from reset
    do_reset(0);
    for (int i = 0; i < 12; i++) begin
      step(1, 32'h1000 + 32'(i * 4), i[0], 0, 0, 0);
      step(0, 0, 0, 1, i[1], 0);
    end
    chk("wrap_total", resolved_total, 32'd12);

    // simultaneous push+resolve with entries present
    step(1, 32'h500, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h504 + 32'(i * 4), i[0], 1, 1, 0);

    // random mix
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 2) != 0, $urandom & 32'hFFFC, 1'($urandom),
           $urandom_range(0, 1) == 1, 1'($urandom), $urandom_range(0, 15) == 0);

    // reset mid-operation with a pending update and a same-cycle resolve
    for (int i = 0; i < 4; i++) step(1, 32'h700 + 32'(i * 4), 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    do_reset(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
